// File: rtl/sts_delay_corr_if.sv
// sts_delay_corr_if: sample stream, delay-line RAM ports and correlation outputs of sts_delay_corr.
interface sts_delay_corr_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5,
  parameter int WIN    = 16
);
  localparam int ACC_W = 2 * DATA_W + 1 + $clog2(WIN);
  logic                     s_valid;
  logic signed [DATA_W-1:0] s_i;
  logic signed [DATA_W-1:0] s_q;
  logic [ADDR_W-1:0]        ram_addra;
  logic [2*DATA_W-1:0]      ram_dina;
  logic                     ram_wea;
  logic [ADDR_W-1:0]        ram_addrb;
  logic                     ram_enb;
  logic [2*DATA_W-1:0]      ram_doutb;
  logic                     corr_valid;
  logic signed [ACC_W-1:0]  corr_re;
  logic signed [ACC_W-1:0]  corr_im;
  logic [ACC_W-1:0]         pow;
  modport master (
    output s_valid, s_i, s_q, ram_doutb,
    input  ram_addra, ram_dina, ram_wea, ram_addrb, ram_enb, corr_valid, corr_re, corr_im, pow
  );
  modport slave (
    input  s_valid, s_i, s_q, ram_doutb,
    output ram_addra, ram_dina, ram_wea, ram_addrb, ram_enb, corr_valid, corr_re, corr_im, pow
  );
endinterface

// File: rtl/sts_delay_corr.sv
// sts_delay_corr: STS delay-and-correlate, WIN-sample moving sum of x[n]*conj(x[n-DELAY]) via an external RAM delay line.
// Define STS_CORR_POWER_EN to add the moving sum of delayed-sample energy on pow; otherwise pow is tied to 0.
module sts_delay_corr #(
  parameter int DATA_W  = 16,
  parameter int DELAY   = 16,
  parameter int WIN     = 16,
  parameter int ADDR_W  = 5,
  parameter int RAM_LAT = 1
) (
  input logic             clka,
  input logic             rstb,
  sts_delay_corr_if.slave io
);
  localparam int PW    = 2 * DATA_W + 1;
  localparam int ACC_W = PW + $clog2(WIN);
  localparam int FW    = $clog2(DELAY + WIN + 1);
  logic [ADDR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [FW-1:0]            fill_q, fill_d;
  logic                     real_d, full_d;
  logic [RAM_LAT-1:0]       v_q, r_q, f_q;
  logic signed [DATA_W-1:0] ci_q [RAM_LAT];
  logic signed [DATA_W-1:0] cq_q [RAM_LAT];
  logic signed [DATA_W-1:0] di, dq;
  logic signed [PW-1:0]     xi, xq, yi, yq;
  logic signed [PW-1:0]     re_d, im_d, re_q, im_q;
  logic                     pv_q, pf_q, cv_q;
  logic signed [PW-1:0]     hre_q [WIN];
  logic signed [PW-1:0]     him_q [WIN];
  logic signed [ACC_W-1:0]  acc_re_q, acc_im_q;
  assign io.ram_wea    = io.s_valid;
  assign io.ram_enb    = io.s_valid;
  assign io.ram_addra  = wr_ptr_q;
  assign io.ram_addrb  = io.s_valid ? wr_ptr_q - ADDR_W'(DELAY) : '0;
  assign io.ram_dina   = io.s_valid ? {io.s_i, io.s_q} : '0;
  assign io.corr_valid = cv_q;
  assign io.corr_re    = acc_re_q;
  assign io.corr_im    = acc_im_q;
  // A sample is "real" once DELAY earlier samples exist; "full" once its window holds only real products.
  always_comb begin
    wr_ptr_d = io.s_valid ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
    fill_d   = (io.s_valid && fill_q != FW'(DELAY + WIN)) ? fill_q + FW'(1) : fill_q;
    real_d   = io.s_valid && fill_q >= FW'(DELAY);
    full_d   = io.s_valid && fill_q >= FW'(DELAY + WIN - 1);
  end
  always_ff @(posedge clka) begin
    if (rstb) begin
      wr_ptr_q <= '0;
      fill_q   <= '0;
      v_q      <= '0;
      r_q      <= '0;
      f_q      <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      fill_q   <= fill_d;
      v_q      <= RAM_LAT'({v_q, io.s_valid});
      r_q      <= RAM_LAT'({r_q, real_d});
      f_q      <= RAM_LAT'({f_q, full_d});
    end
  end
  always_ff @(posedge clka) begin
    ci_q[0] <= io.s_i;
    cq_q[0] <= io.s_q;
    for (int k = 1; k < RAM_LAT; k++) begin
      ci_q[k] <= ci_q[k-1];
      cq_q[k] <= cq_q[k-1];
    end
  end
  always_comb begin
    di   = io.ram_doutb[2*DATA_W-1:DATA_W];
    dq   = io.ram_doutb[DATA_W-1:0];
    xi   = PW'(ci_q[RAM_LAT-1]);
    xq   = PW'(cq_q[RAM_LAT-1]);
    yi   = PW'(di);
    yq   = PW'(dq);
    re_d = r_q[RAM_LAT-1] ? xi * yi + xq * yq : '0;
    im_d = r_q[RAM_LAT-1] ? xq * yi - xi * yq : '0;
  end
  always_ff @(posedge clka) begin
    if (rstb) begin
      pv_q <= 1'b0;
      pf_q <= 1'b0;
      re_q <= '0;
      im_q <= '0;
    end else begin
      pv_q <= v_q[RAM_LAT-1];
      pf_q <= f_q[RAM_LAT-1];
      re_q <= re_d;
      im_q <= im_d;
    end
  end
  // The window only moves on real samples, so bubbles leave the sums untouched.
  always_ff @(posedge clka) begin
    if (rstb) begin
      cv_q     <= 1'b0;
      acc_re_q <= '0;
      acc_im_q <= '0;
      for (int k = 0; k < WIN; k++) begin
        hre_q[k] <= '0;
        him_q[k] <= '0;
      end
    end else begin
      cv_q <= pv_q && pf_q;
      if (pv_q) begin
        acc_re_q <= acc_re_q + ACC_W'(re_q) - ACC_W'(hre_q[WIN-1]);
        acc_im_q <= acc_im_q + ACC_W'(im_q) - ACC_W'(him_q[WIN-1]);
        hre_q[0] <= re_q;
        him_q[0] <= im_q;
        for (int k = 1; k < WIN; k++) begin
          hre_q[k] <= hre_q[k-1];
          him_q[k] <= him_q[k-1];
        end
      end
    end
  end
`ifdef STS_CORR_POWER_EN
  logic signed [PW-1:0]    pw_d, pw_q;
  logic signed [PW-1:0]    hpw_q [WIN];
  logic signed [ACC_W-1:0] acc_pw_q;
  assign pw_d   = r_q[RAM_LAT-1] ? yi * yi + yq * yq : '0;
  assign io.pow = acc_pw_q;
  always_ff @(posedge clka) begin
    if (rstb) begin
      pw_q     <= '0;
      acc_pw_q <= '0;
      for (int k = 0; k < WIN; k++) hpw_q[k] <= '0;
    end else begin
      pw_q <= pw_d;
      if (pv_q) begin
        acc_pw_q <= acc_pw_q + ACC_W'(pw_q) - ACC_W'(hpw_q[WIN-1]);
        hpw_q[0] <= pw_q;
        for (int k = 1; k < WIN; k++) hpw_q[k] <= hpw_q[k-1];
      end
    end
  end
`else
  assign io.pow = '0;
`endif
endmodule

// File: tb/tb_sts_delay_corr.sv
// tb_sts_delay_corr: directed vectors with a scoreboard for sts_delay_corr, driving a behavioural dual-port RAM.
`timescale 1ns/1ps
module tb_sts_delay_corr;
  localparam int DATA_W  = 16;
  localparam int DELAY   = 16;
  localparam int WIN     = 16;
  localparam int ADDR_W  = 5;
  localparam int RAM_LAT = 1;
  localparam int DEPTH   = 2 ** ADDR_W;
  localparam longint M16 = 64'd16000000;
  localparam longint P35 = 64'd34359738368;
  typedef struct {
    longint re;
    longint im;
    longint pw;
    int     cyc;
  } exp_t;
  logic clka = 1'b0;
  logic rstb = 1'b1;
  sts_delay_corr_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .WIN(WIN)) bus ();
  sts_delay_corr #(.DATA_W(DATA_W), .DELAY(DELAY), .WIN(WIN), .ADDR_W(ADDR_W), .RAM_LAT(RAM_LAT)) dut (
    .clka(clka),
    .rstb(rstb),
    .io  (bus)
  );
  logic [2*DATA_W-1:0] mem [DEPTH];
  logic [2*DATA_W-1:0] rd_q [RAM_LAT];
  exp_t exp_q [$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   n_acc = 0;
  bit   addr_chk = 1'b0;
  always #5 clka = ~clka;
  always @(posedge clka) cyc <= cyc + 1;
  always @(posedge clka) begin
    if (bus.ram_wea) mem[bus.ram_addra] <= bus.ram_dina;
    if (bus.ram_enb) rd_q[0] <= mem[bus.ram_addrb];
    for (int k = 1; k < RAM_LAT; k++) rd_q[k] <= rd_q[k-1];
  end
  assign bus.ram_doutb = rd_q[RAM_LAT-1];
  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  // Scoreboard monitor: every corr_valid pops one expectation.
  always @(negedge clka) begin
    if (bus.corr_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected corr_valid at cycle %0d: re %0d im %0d", cyc, bus.corr_re, bus.corr_im);
      end else begin
        mon_e = exp_q.pop_front();
        check("corr_re", bus.corr_re, mon_e.re);
        check("corr_im", bus.corr_im, mon_e.im);
`ifdef STS_CORR_POWER_EN
        check("pow", bus.pow, mon_e.pw);
`else
        check("pow", bus.pow, 0);
`endif
        check("latency cycle", cyc, mon_e.cyc);
      end
    end
  end
  always @(negedge clka) begin
    if (addr_chk) begin
      check("ram_wea", bus.ram_wea, bus.s_valid);
      check("ram_enb", bus.ram_enb, bus.s_valid);
      check("ram_addra", bus.ram_addra, n_acc % DEPTH);
      if (bus.s_valid) check("ram_addrb", bus.ram_addrb, (n_acc - DELAY) & (DEPTH - 1));
    end
  end
  task automatic send(input bit v, input int i, input int q, input bit e,
                      input longint re, input longint im, input longint pw);
    exp_t x;
    bus.s_valid = v;
    bus.s_i = DATA_W'(i);
    bus.s_q = DATA_W'(q);
    if (v && e) begin
      x.re  = re;
      x.im  = im;
      x.pw  = pw;
      x.cyc = cyc + RAM_LAT + 2;
      exp_q.push_back(x);
    end
    @(posedge clka);
    #1;
    if (v) n_acc++;
  endtask
  task automatic do_reset();
    rstb = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_i = '0;
    bus.s_q = '0;
    @(posedge clka);
    #1;
    rstb = 1'b0;
    n_acc = 0;
  endtask
  task automatic drain();
    repeat (8) send(0, 0, 0, 0, 0, 0, 0);
    check("scoreboard drained", exp_q.size(), 0);
    exp_q.delete();
  endtask
  task automatic chk_zero(input string tag);
    check({tag, " corr_valid"}, bus.corr_valid, 0);
    check({tag, " corr_re"}, bus.corr_re, 0);
    check({tag, " corr_im"}, bus.corr_im, 0);
    check({tag, " pow"}, bus.pow, 0);
    check({tag, " ram_wea"}, bus.ram_wea, 0);
    check({tag, " ram_enb"}, bus.ram_enb, 0);
    check({tag, " ram_addra"}, bus.ram_addra, 0);
    check({tag, " ram_addrb"}, bus.ram_addrb, 0);
    check({tag, " ram_dina"}, bus.ram_dina, 0);
  endtask
  initial begin
    bus.s_valid = 1'b0;
    bus.s_i = '0;
    bus.s_q = '0;
    repeat (3) @(posedge clka);
    #1;
    rstb = 1'b0;
    chk_zero("reset");
    addr_chk = 1'b1;
    // Constant (1000,0): first result on the 32nd sample
    for (int k = 1; k <= 34; k++) send(1, 1000, 0, k >= 32, M16, 0, M16);
    drain();
    // 16 x (1000,0) then (0,1000): window of 1000*j1000 products
    do_reset();
    for (int k = 1; k <= 16; k++) send(1, 1000, 0, 0, 0, 0, 0);
    for (int k = 17; k <= 31; k++) send(1, 0, 1000, 0, 0, 0, 0);
    send(1, 0, 1000, 1, 0, M16, M16);
    send(1, 0, 1000, 1, 1000000, 15000000, M16);
    send(1, 0, 1000, 1, 2000000, 14000000, M16);
    drain();
    // Extreme negative full-scale input
    do_reset();
    for (int k = 1; k <= 33; k++) send(1, -32768, -32768, k >= 32, P35, 0, P35);
    drain();
    // Same as the first stream, one sample every third cycle
    do_reset();
    for (int k = 1; k <= 34; k++) begin
      send(1, 1000, 0, k >= 32, M16, 0, M16);
      send(0, 0, 0, 0, 0, 0, 0);
      send(0, 0, 0, 0, 0, 0, 0);
    end
    drain();
    // 100 continuous samples: pointer wraps several times
    do_reset();
    for (int k = 1; k <= 100; k++) send(1, 1000, 0, k >= 32, M16, 0, M16);
    drain();
    // Reset one cycle after sample 40; samples 39 and 40 are in flight and must vanish
    do_reset();
    for (int k = 1; k <= 40; k++) send(1, 1000, 0, k >= 32 && k <= 38, M16, 0, M16);
    do_reset();
    chk_zero("mid-traffic reset");
    for (int k = 1; k <= 34; k++) send(1, 1000, 0, k >= 32, M16, 0, M16);
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sts_delay_corr.md
# sts_delay_corr

Delay-and-correlate stage for 802.11a short-training-sequence (STS) coarse frequency-offset estimation. It writes the incoming I/Q stream into the team's simple dual-port RAM, which serves as a DELAY-sample delay line. It reads the delayed samples back from the same RAM and forms x[n]·conj(x[n−DELAY]). It outputs the WIN-sample moving sum of that product, whose angle the downstream CORDIC stage converts to a coarse CFO.

## Interface
Parameters:
- DATA_W, 16, signed width of each of I and Q.
- DELAY, 16, correlation lag in samples (STS period); 1 ≤ DELAY ≤ 2^ADDR_W − 1.
- WIN, 16, moving-sum length in samples; power of two, ≥ 2.
- ADDR_W, 5, RAM address width (RAM depth 2^ADDR_W, word 2·DATA_W).
- RAM_LAT, 1, RAM read latency in cycles (1 = LOW_LATENCY, 2 = HIGH_PERFORMANCE).

Ports:
- clka  in  1  clock for this block; the RAM's clka and clkb are both tied to it.
- rstb  in  1  reset, synchronous, active-high; clock clka.
- s_valid  in  1  input sample strobe; no backpressure.
- s_i, s_q  in  DATA_W each  signed input sample.
- ram_addra  out  ADDR_W  RAM write address.
- ram_dina  out  2·DATA_W  RAM write data, {I, Q}, I in the MSBs.
- ram_wea  out  1  RAM write enable.
- ram_addrb  out  ADDR_W  RAM read address.
- ram_enb  out  1  RAM read enable.
- ram_doutb  in  2·DATA_W  RAM read data.
- corr_valid  out  1  corr_re, corr_im and pow are valid.
- corr_re, corr_im  out  ACC_W  signed moving-sum correlation; ACC_W = 2·DATA_W + 1 + log2(WIN).
- pow  out  ACC_W  unsigned moving sum of |x[n−DELAY]|² (see Configuration).

## Operation
Write side:
- ram_wea = s_valid; ram_dina = {s_i, s_q}; ram_addra = wr_ptr.
- wr_ptr increments modulo 2^ADDR_W on each s_valid.

Read side:
- ram_enb = s_valid; ram_addrb = (wr_ptr − DELAY) mod 2^ADDR_W, issued in the same cycle as the write.
- The read and write addresses never collide because DELAY ≥ 1.

Pipeline:
- The current sample and a valid tag are delayed RAM_LAT cycles so they align with ram_doutb.
- Product stage (registered): re = i·id + q·qd; im = q·id − i·qd. Full precision, 2·DATA_W+1 bits; no rounding or saturation.
- Fill counter counts accepted samples up to DELAY+WIN, then saturates. A product is "real" only once the counter is ≥ DELAY; earlier products are forced to 0, since RAM contents are never cleared.
- History: WIN-deep shift register of products, advanced only on tagged-valid.
- Accumulator update: acc ← acc + p_new − p_oldest.
- corr_valid pulses one cycle per tagged-valid product once DELAY+WIN samples have been accepted.

Gaps and reset:
- Gaps in s_valid are bubbles. Results depend only on the sample sequence, not on its timing.
- rstb clears wr_ptr, the fill counter, history, accumulators, valid tags and all outputs, with or without traffic in flight.
- A reset during traffic restarts the fill from 0.

## Timing
- Outputs after reset: ram_wea, ram_enb, corr_valid = 0; all address, data, corr_re, corr_im and pow outputs = 0.
- Latency: sample with s_valid in cycle t produces a corr_valid result in cycle t + RAM_LAT + 2. Breakdown: RAM read, product register, accumulator register.
- Throughput: one sample per cycle, sustained.
- The first corr_valid is produced by the (DELAY+WIN)-th accepted sample.
- Pointer wrap from 2^ADDR_W−1 to 0 is seamless; ram_addrb wraps by the same modulo arithmetic.

## Configuration
- STS_CORR_POWER_EN defined: the delayed-sample energy id²+qd² gets its own WIN-deep history and moving sum, output on pow with the same latency and valid as corr.
- STS_CORR_POWER_EN undefined: the power logic is not compiled in and pow is tied to 0.

## Test plan
- Constant input (1000, 0), continuous, DELAY=WIN=16, RAM_LAT=1:
  - first corr_valid 3 cycles after the 32nd sample;
  - corr_re = 16 000 000, corr_im = 0, pow = 16 000 000 (power enabled).
- 16 samples of (1000, 0) followed by a continuous stream of (0, 1000): when the first 16 products fill the window (at the 32nd sample), corr_re = 0 and corr_im = 16 000 000.
- Extreme input (−32768, −32768) continuous: corr_re = 34 359 738 368 (2^35), corr_im = 0; no overflow at ACC_W = 37.
- Same stream as the first scenario with s_valid on every third cycle: identical corr values and number of corr_valid pulses.
- 100 continuous samples:
  - ram_addra wraps 31 → 0;
  - ram_addrb always equals (ram_addra − 16) mod 32;
  - ram_wea and ram_enb follow s_valid exactly.
- rstb asserted for one cycle after sample 40:
  - all outputs are 0 in the following cycle;
  - no corr_valid until 32 new samples have been accepted;
  - values then match the first scenario.
